therm_decoder_8x256: RTL and testbench

//  Binary-to-thermometer decoder; the inverse of the flash-ADC thermometer encoder.

---
 rtl/therm_decoder_8x256.sv | 146 ++++++++++++++
 tb/tb_therm_decoder_8x256.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/therm_decoder_8x256.sv
// Binary-to-thermometer decoder, fed by a valid/ready code stream or an
// internal lo..hi sweep with per-code hold; drives ADC comparator stimulus.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_code/in_valid/in_ready  direct-mode code stream
//   sweep_start/sweep_abort    sweep control
//   sweep_lo/hi/step           sweep range, sampled at start
//   therm_out/code_out         registered thermometer bus and its code
//   out_valid                  pulse when therm_out takes a new code
//   sweep_busy/sweep_done      sweep status
module therm_decoder_8x256 #(
  parameter int CODE_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sweep_start,
  input  logic                   sweep_abort,
  input  logic [CODE_W-1:0]      sweep_lo,
  input  logic [CODE_W-1:0]      sweep_hi,
  input  logic [CODE_W-1:0]      sweep_step,
  output logic [2**CODE_W-1:0]   therm_out,
  output logic [CODE_W-1:0]      code_out,
  output logic                   out_valid,
  output logic                   sweep_busy,
  output logic                   sweep_done
);

  localparam int THERM_W = 2**CODE_W;
  localparam int HOLD_W  =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   code_d;
  logic [THERM_W-1:0]  therm_q;
  logic [THERM_W-1:0]  therm_d;
  logic                load;
  logic [CODE_W-1:0]   hi_q;
  logic [CODE_W-1:0]   hi_d;
  logic [CODE_W-1:0]   step_q;
  logic [CODE_W-1:0]   step_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic                vld_q;
  logic [CODE_W:0]     nxt;
  logic                hold_end;

  // One extra bit so a step past the top code is seen as overflow
  // rather than wrapping back into range.
  assign nxt      = {1'b0, code_q} + {1'b0, step_q};
  assign hold_end = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hi_d    = hi_q;
    step_d  = step_q;
    hold_d  = hold_q;
    load    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (sweep_start) begin
          state_d = SWEEP;
          hi_d    = sweep_hi;
          step_d  = (sweep_step == '0) ?
                    CODE_W'(1) : sweep_step;
          code_d  = sweep_lo;
          hold_d  = '0;
          load    = 1'b1;
        end else if (in_valid) begin
          code_d = in_code;
          load   = 1'b1;
        end
      end
      (state_q == SWEEP): begin
        if (sweep_abort) begin
          state_d = IDLE;
        end else if (hold_end) begin
          hold_d = '0;
          if (nxt > {1'b0, hi_q}) begin
            state_d = DONE;
          end else begin
            code_d = nxt[CODE_W-1:0];
            load   = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    therm_d = '0;
    for (int j = 0; j < THERM_W; j++) begin
      therm_d[j] = (j <= int'(code_d));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      therm_q <= '0;
      vld_q   <= 1'b0;
      hi_q    <= '0;
      step_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      vld_q   <= load;
      hi_q    <= hi_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      if (load) begin
        therm_q <= therm_d;
      end
    end
  end

  assign in_ready   = (state_q == IDLE) && !sweep_start;
  assign therm_out  = therm_q;
  assign code_out   = code_q;
  assign out_valid  = vld_q;
  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_therm_decoder_8x256.sv
// Randomised and directed bench for therm_decoder_8x256 with an
// event-list reference model.
module tb_therm_decoder_8x256;

  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_code;
  logic         in_valid;
  logic         in_ready;
  logic         sweep_start;
  logic         sweep_abort;
  logic [7:0]   sweep_lo;
  logic [7:0]   sweep_hi;
  logic [7:0]   sweep_step;
  logic [255:0] therm_out;
  logic [7:0]   code_out;
  logic         out_valid;
  logic         sweep_busy;
  logic         sweep_done;

  always #5 clk = ~clk;

  therm_decoder_8x256 #(
    .CODE_W(8),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_code(in_code),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sweep_start(sweep_start),
    .sweep_abort(sweep_abort),
    .sweep_lo(sweep_lo),
    .sweep_hi(sweep_hi),
    .sweep_step(sweep_step),
    .therm_out(therm_out),
    .code_out(code_out),
    .out_valid(out_valid),
    .sweep_busy(sweep_busy),
    .sweep_done(sweep_done)
  );

  typedef struct {
    int code;
    bit vld;
    bit busy;
    bit done;
  } ent_t;

  ent_t sched[$];
  ent_t e;
  int   m_code;
  bit   m_has;
  bit   m_vld;
  bit   m_busy;
  bit   m_done;
  int   b_c;
  int   b_st;
  int   b_last;
  int   n_total = 0;
  int   n_pass  = 0;
  int   got[$];

  function automatic logic [255:0] mask(input int k);
    logic [256:0] t;
    t = 257'd1;
    t = (t << (k + 1)) - 257'd1;
    return t[255:0];
  endfunction

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Reference model: a sweep is expanded up front into the list of
  // per-cycle outputs it must produce; abort discards the rest.
  always @(posedge clk) begin
    if (!rst_n) begin
      sched.delete();
      m_code = 0;
      m_has  = 0;
      m_vld  = 0;
      m_busy = 0;
      m_done = 0;
    end else if (sched.size() != 0) begin
      if (sweep_abort && m_busy) begin
        sched.delete();
        m_vld  = 0;
        m_busy = 0;
        m_done = 0;
      end else begin
        e = sched.pop_front();
        m_code = e.code;
        m_vld  = e.vld;
        m_busy = e.busy;
        m_done = e.done;
      end
    end else if (m_done) begin
      m_vld  = 0;
      m_done = 0;
    end else if (sweep_start) begin
      b_st = (sweep_step == 0) ? 1 : int'(sweep_step);
      b_c  = int'(sweep_lo);
      do begin
        for (int h = 0; h < H; h++)
          sched.push_back('{b_c, h == 0, 1'b1, 1'b0});
        b_last = b_c;
        b_c += b_st;
      end while (b_c <= int'(sweep_hi));
      sched.push_back('{b_last, 1'b0, 1'b0, 1'b1});
      e = sched.pop_front();
      m_code = e.code;
      m_vld  = e.vld;
      m_busy = e.busy;
      m_done = e.done;
      m_has  = 1;
    end else if (in_valid) begin
      m_code = int'(in_code);
      m_vld  = 1;
      m_has  = 1;
    end else begin
      m_vld = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_therm", therm_out,
          m_has ? mask(m_code) : 256'h0);
      chk("m_code", code_out, m_code);
      chk("m_valid", out_valid, m_vld);
      chk("m_ready", in_ready,
          sched.size() == 0 && !m_done && !sweep_start);
      chk("m_busy", sweep_busy, m_busy);
      chk("m_done", sweep_done, m_done);
    end
  end

  task automatic sweep_collect(input int lo, input int hi,
                               input int st, output int ncyc);
    bit seen;
    repeat (2) @(negedge clk);
    sweep_lo    = 8'(lo);
    sweep_hi    = 8'(hi);
    sweep_step  = 8'(st);
    sweep_start = 1'b1;
    got.delete();
    ncyc = 0;
    seen = 0;
    while (!seen && ncyc < 1200) begin
      @(posedge clk);
      #2;
      ncyc++;
      if (out_valid) got.push_back(int'(code_out));
      if (sweep_done) seen = 1;
      @(negedge clk);
      sweep_start = 1'b0;
    end
    chk("sweep_done_seen", seen, 1);
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    chk({name, "_n"}, got.size(), exp.size());
    foreach (exp[i])
      chk(name, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  int   n;
  bit   any_done;
  bit   any_vld;
  logic [255:0] held;

  initial begin
    rst_n       = 1'b0;
    in_code     = '0;
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    sweep_lo    = '0;
    sweep_hi    = '0;
    sweep_step  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_therm", therm_out, 256'h0);
    chk("rst_code", code_out, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);

    @(negedge clk); in_code = 8'd0; in_valid = 1'b1;
    @(posedge clk); #2;
    chk("dir0_therm", therm_out, 256'h1);
    chk("dir0_valid", out_valid, 1);
    @(negedge clk); in_code = 8'd255;
    @(posedge clk); #2;
    chk("dir255", therm_out, {256{1'b1}});
    @(negedge clk); in_code = 8'd127;
    @(posedge clk); #2;
    chk("dir127", therm_out, {{128{1'b0}}, {128{1'b1}}});
    @(negedge clk); in_code = 8'd3;
    @(posedge clk); #2;
    chk("dir3", therm_out, 256'hF);
    chk("dir3_code", code_out, 3);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2;
    chk("dir_pulse", out_valid, 0);
    chk("dir_hold", therm_out, 256'hF);

    for (int k = 0; k < 256; k++) begin
      @(negedge clk); in_code = 8'(k); in_valid = 1'b1;
      @(posedge clk); #2;
      chk("roundtrip", $countones(therm_out) - 1, k);
      chk("therm_shape", therm_out & (therm_out + 256'd1), 0);
    end
    @(negedge clk); in_valid = 1'b0;

    sweep_collect(250, 255, 2, n);
    chk_got("sw250", '{250, 252, 254});
    chk("sw250_cycles", n, 13);
    chk("sw250_last", code_out, 254);
    chk("sw250_therm", {therm_out[255], therm_out[254]}, 2'b01);

    sweep_collect(10, 5, 7, n);
    chk_got("sw_lohi", '{10});
    chk("sw_lohi_cycles", n, 5);
    chk("sw_lohi_last", code_out, 10);

    sweep_collect(20, 23, 0, n);
    chk_got("sw_step0", '{20, 21, 22, 23});
    chk("sw_step0_cycles", n, 17);

    repeat (2) @(negedge clk);
    in_code     = 8'd77;
    in_valid    = 1'b1;
    sweep_lo    = 8'd100;
    sweep_hi    = 8'd200;
    sweep_step  = 8'd1;
    sweep_start = 1'b1;
    #1;
    chk("start_ready", in_ready, 0);
    @(posedge clk); #2;
    chk("start_prio", code_out, 100);
    chk("start_busy", sweep_busy, 1);
    @(negedge clk); sweep_start = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    sweep_abort = 1'b1;
    held = therm_out;
    chk("abort_code", code_out, 101);
    @(negedge clk); sweep_abort = 1'b0;
    any_done = 0;
    any_vld  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      any_done |= sweep_done;
      any_vld  |= out_valid;
    end
    chk("abort_nodone", any_done, 0);
    chk("abort_novalid", any_vld, 0);
    chk("abort_idle", sweep_busy, 0);
    chk("abort_hold", therm_out, held);

    repeat (2) @(negedge clk);
    sweep_lo    = 8'd0;
    sweep_hi    = 8'd255;
    sweep_step  = 8'd1;
    sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_therm", therm_out, 256'h0);
    chk("arst_code", code_out, 0);
    chk("arst_busy", sweep_busy, 0);
    chk("arst_done", sweep_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); in_code = 8'd42; in_valid = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_code", code_out, 42);
    chk("post_rst_bits", {therm_out[43], therm_out[42]}, 2'b01);
    @(negedge clk); in_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid    = 1'($urandom_range(0, 1));
      in_code     = 8'($urandom);
      sweep_start = ($urandom_range(0, 19) == 0);
      sweep_abort = ($urandom_range(0, 39) == 0);
      sweep_lo    = 8'($urandom);
      sweep_hi    = 8'($urandom);
      sweep_step  = 8'($urandom_range(0, 63));
    end
    @(negedge clk);
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    sweep_abort = 1'b1;
    repeat (4) @(negedge clk);
    sweep_abort = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
